// File: rtl/osiris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osiris_pkg
// Description : Shared types and constants for the IF-stage fetch controller.
//               fetch_state_t : fetch sequencer states
//               NOP_INSTR     : word presented to ID while no instruction is
//                               valid (addi x0, x0, 0)
//               BOOT_CNT_W    : width of the post-reset boot delay counter
// Revision    : 1.0 - initial release
// ============================================================================
package osiris_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          BOOT_CNT_W = 4;

endpackage : osiris_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : Two-entry IF->ID buffer. The "out" entry drives ID directly;
//               the "skid" entry catches a word that returns while ID is
//               stalled on a full out entry. The skid always drains into the
//               out entry before a new word may land there, so ordering is
//               preserved.
// Ports       : clk           in   clock, rising edge
//               i_rst_IF      in   asynchronous active-high reset
//               i_push        in   store i_push_instr/i_push_pc this edge
//               i_push_instr  in   fetched instruction word
//               i_push_pc     in   address of the fetched word
//               i_pop         in   ID consumes the out entry this edge
//               i_flush       in   discard both entries (wins over push/pop)
//               o_out_valid   out  out entry holds a valid word
//               o_out_instr   out  out entry instruction
//               o_out_pc      out  out entry address
//               o_skid_valid  out  skid entry holds a valid word
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import osiris_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_rst_IF,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_instr,
    input  logic [DATA_WIDTH-1:0] i_push_pc,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_instr,
    output logic [DATA_WIDTH-1:0] o_out_pc,
    output logic                  o_skid_valid
);

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_instr;
    logic [DATA_WIDTH-1:0] r_out_pc;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_instr;
    logic [DATA_WIDTH-1:0] r_skid_pc;

    // The out slot can take a new word when it is empty or being consumed.
    logic w_out_free;
    assign w_out_free = !r_out_valid || i_pop;

    always_ff @(posedge clk or posedge i_rst_IF) begin
        if (i_rst_IF) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= DATA_WIDTH'(NOP_INSTR);
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= DATA_WIDTH'(NOP_INSTR);
            r_skid_pc    <= '0;
        end else if (i_flush) begin
            // Data registers keep their contents; only the valid flags matter.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Oldest word (skid) advances; a simultaneous arrival
                // takes its place in the skid.
                r_out_valid  <= 1'b1;
                r_out_instr  <= r_skid_instr;
                r_out_pc     <= r_skid_pc;
                r_skid_valid <= i_push;
                if (i_push) begin
                    r_skid_instr <= i_push_instr;
                    r_skid_pc    <= i_push_pc;
                end
            end else if (i_push) begin
                r_out_valid <= 1'b1;
                r_out_instr <= i_push_instr;
                r_out_pc    <= i_push_pc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (i_push) begin
            // Out entry is held by a stalled ID: park the arrival.
            r_skid_valid <= 1'b1;
            r_skid_instr <= i_push_instr;
            r_skid_pc    <= i_push_pc;
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_out_instr  = r_out_instr;
    assign o_out_pc     = r_out_pc;
    assign o_skid_valid = r_skid_valid;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : IF-stage sequencer. Controls the PC register (enable, source,
//               redirect target), issues req/ack instruction-memory fetches
//               and hands fetched words to ID through fetch_skid_buf.
//               EX redirects arriving while a fetch is outstanding are held
//               until the ack; the stale response is then dropped.
// Ports       : clk                  in   clock, rising edge
//               i_rst_IF             in   asynchronous active-high reset
//               i_pc_IF              in   current PC from the PC register
//               o_en_IF              out  PC register load enable
//               o_pc_src_IF          out  0 = PC+4, 1 = o_pc_target_IF
//               o_pc_target_IF       out  word-aligned redirect target
//               o_imem_req           out  fetch request
//               o_imem_addr          out  fetch address, stable until ack
//               i_imem_ack           in   response valid
//               i_imem_rdata         in   instruction word (with ack)
//               i_redirect_EX        in   taken branch/jump pulse
//               i_redirect_target_EX in   redirect address
//               i_stall_ID           in   ID cannot consume this cycle
//               o_valid_ID           out  o_instr_ID/o_pc_ID valid
//               o_instr_ID           out  fetched instruction
//               o_pc_ID              out  address of o_instr_ID
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import osiris_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BOOT_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  i_rst_IF,
    input  logic [DATA_WIDTH-1:0] i_pc_IF,
    output logic                  o_en_IF,
    output logic                  o_pc_src_IF,
    output logic [DATA_WIDTH-1:0] o_pc_target_IF,
    output logic                  o_imem_req,
    output logic [DATA_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_ack,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    input  logic                  i_redirect_EX,
    input  logic [DATA_WIDTH-1:0] i_redirect_target_EX,
    input  logic                  i_stall_ID,
    output logic                  o_valid_ID,
    output logic [DATA_WIDTH-1:0] o_instr_ID,
    output logic [DATA_WIDTH-1:0] o_pc_ID
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    fetch_state_t          r_state;
    logic [BOOT_CNT_W-1:0] r_boot_cnt;
    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_addr;
    logic                  r_pend;
    logic [DATA_WIDTH-1:0] r_pend_target;

    // ------------------------------------------------------------------
    // Buffer interface
    // ------------------------------------------------------------------
    logic                  w_out_valid;
    logic                  w_skid_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;

    // ------------------------------------------------------------------
    // PC control
    // ------------------------------------------------------------------
    logic                  w_ack;
    logic [DATA_WIDTH-1:0] w_redir_tgt;
    logic                  w_en;
    logic                  w_src;
    logic [DATA_WIDTH-1:0] w_target;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_to_skid;
    logic                  w_issue_ok;

    localparam logic [BOOT_CNT_W-1:0] c_boot_last = BOOT_CNT_W'(BOOT_DELAY - 1);

    // An ack with no request outstanding carries nothing for us.
    assign w_ack       = i_imem_ack && r_req;
    assign w_redir_tgt = i_redirect_target_EX & ~DATA_WIDTH'(3);

    assign w_pop   = w_out_valid && !i_stall_ID;
    assign w_flush = i_redirect_EX;

    // PC register control. The PC may only move when no fetch is in flight
    // (idle) or on the cycle the in-flight fetch completes; otherwise the
    // outstanding address would stop matching the PC. A live redirect beats
    // a held one, and a held one beats a plain sequential advance; in both
    // redirect cases the returning word is stale and is not pushed.
    always_comb begin
        w_en     = 1'b0;
        w_src    = 1'b0;
        w_target = '0;
        w_push   = 1'b0;
        if (r_state != BOOT && (!r_req || w_ack)) begin
            if (i_redirect_EX) begin
                w_en     = 1'b1;
                w_src    = 1'b1;
                w_target = w_redir_tgt;
            end else if (r_pend) begin
                w_en     = 1'b1;
                w_src    = 1'b1;
                w_target = r_pend_target;
            end else if (w_ack) begin
                w_en   = 1'b1;
                w_push = 1'b1;
            end
        end
    end

    // Value the PC register will hold after this edge; a request started
    // at this edge must use it, not the pre-edge i_pc_IF.
    assign w_next_pc = !w_en ? i_pc_IF
                     : (w_src ? w_target : i_pc_IF + DATA_WIDTH'(4));

    // Arrival lands in the skid when the out entry is full and held.
    assign w_to_skid = w_push && w_out_valid && i_stall_ID;

    // A new request is allowed only when its response is guaranteed a slot:
    // skid empty and the out entry free or draining. A redirect empties
    // both entries at this edge, so it always leaves room.
    assign w_issue_ok = (r_state == FETCH) &&
                        (i_redirect_EX || (!w_skid_valid && (!w_out_valid || !i_stall_ID)));

    // ------------------------------------------------------------------
    // Sequencer: state, boot counter, request and redirect latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge i_rst_IF) begin
        if (i_rst_IF) begin
            r_state       <= BOOT;
            r_boot_cnt    <= '0;
            r_req         <= 1'b0;
            r_addr        <= '0;
            r_pend        <= 1'b0;
            r_pend_target <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    if (r_boot_cnt == c_boot_last) begin
                        r_state <= FETCH;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + BOOT_CNT_W'(1);
                    end
                end
                FETCH: begin
                    if (w_to_skid) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    // Releasing the stall drains skid into out at this edge.
                    if (i_redirect_EX || !i_stall_ID) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= BOOT;
            endcase

            // Redirects that cannot be applied yet (boot, or fetch in flight)
            // are held; the newest one overwrites any older one. Whenever the
            // PC is free to move the held redirect is consumed above.
            if (r_state == BOOT || (r_req && !w_ack)) begin
                if (i_redirect_EX) begin
                    r_pend        <= 1'b1;
                    r_pend_target <= w_redir_tgt;
                end
            end else begin
                r_pend <= 1'b0;
            end

            // Request: held with a frozen address until acked, then either
            // re-issued back-to-back or dropped.
            if (r_state == BOOT) begin
                r_req <= 1'b0;
            end else if (r_req && !w_ack) begin
                r_req <= 1'b1;
            end else if (w_issue_ok) begin
                r_req  <= 1'b1;
                r_addr <= w_next_pc;
            end else begin
                r_req <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Out + skid buffer
    // ------------------------------------------------------------------
    fetch_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk          (clk),
        .i_rst_IF     (i_rst_IF),
        .i_push       (w_push),
        .i_push_instr (i_imem_rdata),
        .i_push_pc    (r_addr),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .o_out_valid  (w_out_valid),
        .o_out_instr  (o_instr_ID),
        .o_out_pc     (o_pc_ID),
        .o_skid_valid (w_skid_valid)
    );

    assign o_valid_ID     = w_out_valid;
    assign o_en_IF        = w_en;
    assign o_pc_src_IF    = w_src;
    assign o_pc_target_IF = w_target;
    assign o_imem_req     = r_req;
    assign o_imem_addr    = r_addr;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl. Models the PC
//               register and a fixed-latency instruction memory whose data
//               word is 0xA0000000 | address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        en, src;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] redir_tgt;
    logic        stall;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_id;

    logic [3:0]  mem_lat;
    logic [3:0]  mem_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .DATA_WIDTH (32),
        .BOOT_DELAY (2)
    ) dut (
        .clk                  (clk),
        .i_rst_IF             (rst),
        .i_pc_IF              (pc),
        .o_en_IF              (en),
        .o_pc_src_IF          (src),
        .o_pc_target_IF       (target),
        .o_imem_req           (req),
        .o_imem_addr          (addr),
        .i_imem_ack           (ack),
        .i_imem_rdata         (rdata),
        .i_redirect_EX        (redir),
        .i_redirect_target_EX (redir_tgt),
        .i_stall_ID           (stall),
        .o_valid_ID           (valid),
        .o_instr_ID           (instr),
        .o_pc_ID              (pc_id)
    );

    // PC register model
    always @(posedge clk or posedge rst) begin
        if (rst)      pc <= 32'h0;
        else if (en)  pc <= src ? target : pc + 32'd4;
    end

    // Memory: ack after mem_lat waiting cycles (0 = same cycle as req)
    assign ack   = req && (mem_cnt == mem_lat);
    assign rdata = 32'hA000_0000 | addr;
    always @(posedge clk or posedge rst) begin
        if (rst)              mem_cnt <= 4'd0;
        else if (!req || ack) mem_cnt <= 4'd0;
        else                  mem_cnt <= mem_cnt + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 2 time units after the last reset edge ("cycle 0").
    task automatic reset_dut(input logic [3:0] lat);
        rst     = 1'b1;
        mem_lat = lat;
        stall   = 1'b0;
        redir   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        redir     = 1'b0;
        redir_tgt = 32'h0;
        mem_lat   = 4'd0;

        // ---- 1: boot and back-to-back zero-wait fetch -------------------
        reset_dut(4'd0);
        chk("rst_req",    req,    32'h0);
        chk("rst_addr",   addr,   32'h0);
        chk("rst_valid",  valid,  32'h0);
        chk("rst_instr",  instr,  32'h0000_0013);
        chk("rst_pc_id",  pc_id,  32'h0);
        chk("rst_en",     en,     32'h0);
        chk("rst_src",    src,    32'h0);
        chk("rst_target", target, 32'h0);
        next(); #1;
        chk("t1_c1_req", req, 32'h0);
        next(); #1;
        chk("t1_c2_req", req, 32'h0);
        chk("t1_c2_en",  en,  32'h0);
        next(); #1;
        chk("t1_c3_req",  req,  32'h1);
        chk("t1_c3_addr", addr, 32'h0);
        chk("t1_c3_en",   en,   32'h1);
        chk("t1_c3_src",  src,  32'h0);
        next(); #1;
        chk("t1_c4_valid", valid, 32'h1);
        chk("t1_c4_pc_id", pc_id, 32'h0);
        chk("t1_c4_instr", instr, 32'hA000_0000);
        chk("t1_c4_en",    en,    32'h1);
        chk("t1_c4_addr",  addr,  32'h4);
        next(); #1;
        chk("t1_c5_pc_id", pc_id, 32'h4);
        chk("t1_c5_valid", valid, 32'h1);
        chk("t1_c5_en",    en,    32'h1);
        next(); #1;
        chk("t1_c6_pc_id", pc_id, 32'h8);
        chk("t1_c6_en",    en,    32'h1);

        // ---- 2: stall with 1-cycle memory, skid and HOLD ----------------
        reset_dut(4'd1);
        next(); next(); next(); next(); #1;
        chk("t2_c4_en",   en,   32'h1);
        chk("t2_c4_addr", addr, 32'h0);
        next(); #1;
        chk("t2_c5_pc_id", pc_id, 32'h0);
        chk("t2_c5_addr",  addr,  32'h4);
        chk("t2_c5_en",    en,    32'h0);
        next(); #1;
        chk("t2_c6_en",    en,    32'h1);
        chk("t2_c6_valid", valid, 32'h0);
        next(); stall = 1'b1; #1;
        chk("t2_c7_pc_id", pc_id, 32'h4);
        chk("t2_c7_addr",  addr,  32'h8);
        chk("t2_c7_en",    en,    32'h0);
        next(); #1;
        chk("t2_c8_en",    en,    32'h1);
        chk("t2_c8_pc_id", pc_id, 32'h4);
        next(); #1;
        chk("t2_c9_req",   req,   32'h0);
        chk("t2_c9_en",    en,    32'h0);
        chk("t2_c9_pc_id", pc_id, 32'h4);
        chk("t2_c9_valid", valid, 32'h1);
        next(); stall = 1'b0; #1;
        chk("t2_c10_pc_id", pc_id, 32'h4);
        chk("t2_c10_req",   req,   32'h0);
        chk("t2_c10_en",    en,    32'h0);
        next(); #1;
        chk("t2_c11_pc_id", pc_id, 32'h8);
        chk("t2_c11_instr", instr, 32'hA000_0008);
        chk("t2_c11_req",   req,   32'h0);
        next(); #1;
        chk("t2_c12_valid", valid, 32'h0);
        chk("t2_c12_req",   req,   32'h1);
        chk("t2_c12_addr",  addr,  32'hC);
        next(); #1;
        chk("t2_c13_en", en, 32'h1);
        next(); #1;
        chk("t2_c14_pc_id", pc_id, 32'hC);
        chk("t2_c14_valid", valid, 32'h1);

        // ---- 3: redirect while request outstanding (3-cycle memory) -----
        reset_dut(4'd3);
        next(); next(); next(); #1;
        chk("t3_c3_req",  req,  32'h1);
        chk("t3_c3_addr", addr, 32'h0);
        next(); redir = 1'b1; redir_tgt = 32'h103; #1;
        chk("t3_c4_en", en, 32'h0);
        next(); redir = 1'b0; #1;
        chk("t3_c5_en",   en,   32'h0);
        chk("t3_c5_addr", addr, 32'h0);
        next(); #1;
        chk("t3_c6_en",     en,     32'h1);
        chk("t3_c6_src",    src,    32'h1);
        chk("t3_c6_target", target, 32'h100);
        next(); #1;
        chk("t3_c7_valid", valid, 32'h0);
        chk("t3_c7_addr",  addr,  32'h100);
        chk("t3_c7_en",    en,    32'h0);
        next(); next(); next(); #1;
        chk("t3_c10_en",    en,    32'h1);
        chk("t3_c10_src",   src,   32'h0);
        chk("t3_c10_valid", valid, 32'h0);
        next(); #1;
        chk("t3_c11_valid", valid, 32'h1);
        chk("t3_c11_pc_id", pc_id, 32'h100);
        chk("t3_c11_instr", instr, 32'hA000_0100);
        chk("t3_c11_addr",  addr,  32'h104);

        // ---- 4: newest pending redirect wins; redirect coincident w/ ack -
        next(); redir = 1'b1; redir_tgt = 32'h200; #1;
        chk("t4_c12_en",    en,    32'h0);
        chk("t4_c12_valid", valid, 32'h0);
        next(); redir_tgt = 32'h300; #1;
        chk("t4_c13_en", en, 32'h0);
        next(); redir = 1'b0; #1;
        chk("t4_c14_en",     en,     32'h1);
        chk("t4_c14_src",    src,    32'h1);
        chk("t4_c14_target", target, 32'h300);
        next(); #1;
        chk("t4_c15_addr",  addr,  32'h300);
        chk("t4_c15_valid", valid, 32'h0);
        next(); next(); next(); redir = 1'b1; redir_tgt = 32'h401; #1;
        chk("t4_c18_en",     en,     32'h1);
        chk("t4_c18_src",    src,    32'h1);
        chk("t4_c18_target", target, 32'h400);
        next(); redir = 1'b0; #1;
        chk("t4_c19_addr",  addr,  32'h400);
        chk("t4_c19_valid", valid, 32'h0);
        next(); next(); next(); #1;
        chk("t4_c22_en",  en,  32'h1);
        chk("t4_c22_src", src, 32'h0);
        next(); #1;
        chk("t4_c23_pc_id", pc_id, 32'h400);
        chk("t4_c23_valid", valid, 32'h1);
        chk("t4_c23_req",   req,   32'h1);
        chk("t4_c23_addr",  addr,  32'h404);

        // ---- 5: asynchronous reset during an outstanding request --------
        rst = 1'b1;
        #1;
        chk("t5_req",   req,   32'h0);
        chk("t5_valid", valid, 32'h0);
        chk("t5_instr", instr, 32'h0000_0013);
        chk("t5_pc_id", pc_id, 32'h0);
        chk("t5_addr",  addr,  32'h0);
        chk("t5_en",    en,    32'h0);

        // ---- redirect during BOOT becomes the first PC load -------------
        mem_lat = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        next(); redir = 1'b1; redir_tgt = 32'h500; #1;
        chk("tb_c1_en",  en,  32'h0);
        chk("tb_c1_req", req, 32'h0);
        next(); redir = 1'b0; #1;
        chk("tb_c2_en",     en,     32'h1);
        chk("tb_c2_src",    src,    32'h1);
        chk("tb_c2_target", target, 32'h500);
        chk("tb_c2_req",    req,    32'h0);
        next(); #1;
        chk("tb_c3_req",  req,  32'h1);
        chk("tb_c3_addr", addr, 32'h500);
        chk("tb_c3_src",  src,  32'h0);
        next(); #1;
        chk("tb_c4_pc_id", pc_id, 32'h500);
        chk("tb_c4_valid", valid, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
